// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared state encoding, defaults and helpers for the dm arbiter
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        S_CPU = 2'b00,
        S_EXT = 2'b01,
        S_RSP = 2'b10
    } arb_state_t;

    localparam int DEF_AW         = 7;
    localparam int DEF_DW         = 32;
    localparam int DEF_STARVE_MAX = 4;

    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dm_arbiter_starve_cnt.sv
// rtl/dm_arbiter_starve_cnt.sv - saturating starvation counter for the external requester
module dm_arbiter_starve_cnt #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [W-1:0] cnt;

    // With MAX=0 the counter never leaves zero, so at_max is permanently true.
    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - shares single-port data memory between the CPU data port and an external requester
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] dm_dout
);

    localparam int CW = cnt_width(STARVE_MAX);

    arb_state_t    state, state_nxt;
    logic          ext_we_q;
    logic [AW-1:0] ext_addr_q;
    logic [DW-1:0] ext_wdata_q;
    logic          in_cpu, accept, at_max, cnt_inc, cnt_clr;

    assign in_cpu  = (state == S_CPU);
    assign accept  = in_cpu & ext_req & (~cpu_req | at_max);
    assign cnt_inc = in_cpu & ext_req & cpu_req & ~accept;
    assign cnt_clr = in_cpu & ~cnt_inc;

    dm_arbiter_starve_cnt #(
        .MAX (STARVE_MAX),
        .W   (CW)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .at_max (at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CPU;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_CPU;
        case (state)
            S_CPU:   state_nxt = accept ? S_EXT : S_CPU;
            S_EXT:   state_nxt = S_RSP;
            S_RSP:   state_nxt = S_CPU;
            default: state_nxt = S_CPU;
        endcase
    end

    // dm follows state combinationally so an async reset in S_EXT cancels the pending write.
    always_comb begin
        dm_we     = cpu_req & cpu_we;
        dm_addr   = cpu_addr;
        dm_din    = cpu_wdata;
        cpu_stall = 1'b0;
        ext_gnt   = accept;
        if (state == S_EXT) begin
            dm_we     = ext_we_q;
            dm_addr   = ext_addr_q;
            dm_din    = ext_wdata_q;
            cpu_stall = cpu_req;
        end
    end

    assign cpu_rdata = dm_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_rvalid  <= 1'b0;
            ext_rdata   <= '0;
        end else begin
            if (accept) begin
                ext_we_q    <= ext_we;
                ext_addr_q  <= ext_addr;
                ext_wdata_q <= ext_wdata;
            end
            ext_rvalid <= (state == S_EXT);
            if (state == S_EXT) begin
                ext_rdata <= dm_dout;
            end
        end
    end

endmodule
